// File: rtl/swt16_pkg.sv
// Shared sizing and helpers for the swt16 core register file.
package swt16_pkg;

  localparam int IALU_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;
  localparam int NUM_REGS        = 2 ** REG_IDX_WIDTH;

  localparam logic [REG_IDX_WIDTH-1:0] REG_ZERO = '0;

  // True when an index names a real register rather than the hardwired r0.
  function automatic logic idx_live(input logic [REG_IDX_WIDTH-1:0] idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits and the decode stall decision (RAW on both read
// ports, WAW on the claimed destination). Control only, no data path.
module reg_scoreboard
  import swt16_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [REG_IDX_WIDTH-1:0] wr_idx,
  input  logic                     rd_a_en,
  input  logic [REG_IDX_WIDTH-1:0] rd_a_idx,
  input  logic                     rd_b_en,
  input  logic [REG_IDX_WIDTH-1:0] rd_b_idx,
  input  logic                     claim,
  input  logic [REG_IDX_WIDTH-1:0] claim_idx,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      pending
);

  logic wr_live;
  logic hz_a;
  logic hz_b;
  logic hz_claim;
  logic claim_ok;

  // A retiring write to the same index resolves the hazard in its own cycle,
  // so each term is masked by a matching live write.
  always_comb begin
    wr_live  = wr_en && idx_live(wr_idx);
    hz_a     = rd_a_en && idx_live(rd_a_idx) && pending[rd_a_idx] &&
               !(wr_live && (wr_idx == rd_a_idx));
    hz_b     = rd_b_en && idx_live(rd_b_idx) && pending[rd_b_idx] &&
               !(wr_live && (wr_idx == rd_b_idx));
    hz_claim = claim && idx_live(claim_idx) && pending[claim_idx] &&
               !(wr_live && (wr_idx == claim_idx));
    stall    = hz_a || hz_b || hz_claim;
    claim_ok = claim && idx_live(claim_idx) && !stall;
  end

  // Clear on writeback first, then set on accepted claim so a same-index
  // claim leaves the register pending. r0 can never be set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wr_live)  pending[wr_idx]    <= 1'b0;
      if (claim_ok) pending[claim_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile.sv
// swt16 general-purpose register file: 16 x 16-bit array written by
// writeback, two combinational read ports with write bypass, and a pending
// scoreboard that drives the decode stall.
module regfile
  import swt16_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_write_res_to_reg,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_rd_a_en,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_a_idx,
  input  logic                       in_rd_b_en,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_b_idx,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_a_data,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_b_data,
  input  logic                       in_act_claim,
  input  logic [REG_IDX_WIDTH-1:0]   in_claim_idx,
  output logic                       out_stall,
  output logic [NUM_REGS-1:0]        out_pending
);

  logic [IALU_WORD_WIDTH-1:0] regs [NUM_REGS];
  logic                       wr_live;

  assign wr_live = in_act_write_res_to_reg && idx_live(in_res_reg_idx);

  // Array update; r0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[in_res_reg_idx] <= in_res;
    end
  end

  // Read muxes: r0 masks to zero, a same-index live write bypasses the array.
  always_comb begin
    if (!idx_live(in_rd_a_idx))
      out_rd_a_data = '0;
    else if (wr_live && (in_res_reg_idx == in_rd_a_idx))
      out_rd_a_data = in_res;
    else
      out_rd_a_data = regs[in_rd_a_idx];

    if (!idx_live(in_rd_b_idx))
      out_rd_b_data = '0;
    else if (wr_live && (in_res_reg_idx == in_rd_b_idx))
      out_rd_b_data = in_res;
    else
      out_rd_b_data = regs[in_rd_b_idx];
  end

  reg_scoreboard u_sb (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (in_act_write_res_to_reg),
    .wr_idx    (in_res_reg_idx),
    .rd_a_en   (in_rd_a_en),
    .rd_a_idx  (in_rd_a_idx),
    .rd_b_en   (in_rd_b_en),
    .rd_b_idx  (in_rd_b_idx),
    .claim     (in_act_claim),
    .claim_idx (in_claim_idx),
    .stall     (out_stall),
    .pending   (out_pending)
  );

endmodule
